pin_pulse_capture: RTL and testbench



---
 rtl/pulse_capture_pkg.sv | 12 +
 rtl/pin_sync.sv | 26 ++
 rtl/pin_pulse_capture.sv | 126 ++++++++++++
 tb/tb_pin_pulse_capture.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_capture_pkg.sv
// pulse_capture_pkg: shared state encoding and default timing constants for the pin pulse capture block
package pulse_capture_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_RISE = 3'd1,
    MEASURE   = 3'd2,
    DONE      = 3'd3,
    TRIG      = 3'd4
  } state_t;
  localparam int DEF_TIMEOUT     = 2000000;
  localparam int DEF_TRIG_CYCLES = 500;
endpackage

// File: rtl/pin_sync.sv
// pin_sync: multi-flop synchroniser for an asynchronous pin plus one-cycle rise/fall detect
module pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic pin_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  // shift the raw pin through the chain and remember the previous synchronised level
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = s_o & ~prev_q;
  assign fall_o = ~s_o & prev_q;
endmodule

// File: rtl/pin_pulse_capture.sv
// pin_pulse_capture: measures the high width of a synchronised pin pulse; PULSE_CAPTURE_TRIG_EN adds a trigger output phase
module pin_pulse_capture
  import pulse_capture_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int TRIG_CYCLES = DEF_TRIG_CYCLES
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pin_in,
  input  logic             arm,
  input  logic             rd_ack,
  output logic [CNT_W-1:0] width_out,
  output logic             valid,
  output logic             timeout,
`ifdef PULSE_CAPTURE_TRIG_EN
  output logic             trig_out,
`endif
  output logic             busy
);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TRIG_M1 = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
`ifdef PULSE_CAPTURE_TRIG_EN
  localparam state_t ARM_ST = TRIG;
  logic trig_q;
  assign trig_out = trig_q;
`else
  localparam state_t ARM_ST = WAIT_RISE;
`endif
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] width_q;
  logic             valid_q;
  logic             timeout_q;
  logic             busy_q;
  logic             s;
  logic             rise;
  logic             fall;
  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .clr   (clr),
    .pin_i (pin_in),
    .s_o   (s),
    .rise_o(rise),
    .fall_o(fall)
  );
  // capture sequencer: state, cycle counter and every output live in one register set
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      width_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef PULSE_CAPTURE_TRIG_EN
      trig_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_q   <= ARM_ST;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
`ifdef PULSE_CAPTURE_TRIG_EN
            trig_q    <= 1'b1;
`endif
          end else if (rd_ack && state_q == DONE) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        TRIG: begin
          if (cnt_q == TRIG_M1) begin
            state_q <= WAIT_RISE;
            cnt_q   <= '0;
`ifdef PULSE_CAPTURE_TRIG_EN
            trig_q  <= 1'b0;
`endif
          end else cnt_q <= cnt_q + ONE;
        end
        WAIT_RISE: begin
          if (rise) begin
            state_q <= MEASURE;
            cnt_q   <= ONE;
          end else if (cnt_q == TO_M1) begin
            state_q   <= DONE;
            width_q   <= '0;
            timeout_q <= 1'b1;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
          end else cnt_q <= cnt_q + ONE;
        end
        MEASURE: begin
          if (fall) begin
            state_q   <= DONE;
            width_q   <= cnt_q;
            timeout_q <= 1'b0;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
          end else if (s && cnt_q == TO_C) begin
            state_q   <= DONE;
            width_q   <= TO_C;
            timeout_q <= 1'b1;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
          end else if (s) cnt_q <= cnt_q + ONE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  assign width_out = width_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_pin_pulse_capture.sv
// tb_pin_pulse_capture: directed and random pin waveforms checked cycle by cycle against a capture-level model
module tb_pin_pulse_capture;
  localparam int TO = 100, SY = 2, TC = 5, CW = 32, MAXL = 3000, PL = MAXL + 300;
`ifdef PULSE_CAPTURE_TRIG_EN
  localparam int TD = TC;
`else
  localparam int TD = 0;
`endif
  logic clk = 1'b0, clr = 1'b0, pin_in = 1'b0, arm = 1'b0, rd_ack = 1'b0;
  logic [CW-1:0] width_out;
  logic valid, timeout, busy;
`ifdef PULSE_CAPTURE_TRIG_EN
  logic trig_out;
`endif
  bit pin_a[PL];
  bit arm_a[MAXL], ack_a[MAXL];
  bit e_v[MAXL], e_t[MAXL], e_b[MAXL], e_g[MAXL];
  int e_w[MAXL];
  int n_vec = 0, n_err = 0;

  pin_pulse_capture #(.CNT_W(CW), .SYNC_STAGES(SY), .TIMEOUT(TO), .TRIG_CYCLES(TC)) dut (
    .clk      (clk),
    .clr      (clr),
    .pin_in   (pin_in),
    .arm      (arm),
    .rd_ack   (rd_ack),
    .width_out(width_out),
    .valid    (valid),
    .timeout  (timeout),
`ifdef PULSE_CAPTURE_TRIG_EN
    .trig_out (trig_out),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // synchronised level the FSM sees at edge e: the pin as driven SY cycles earlier
  function automatic bit s_at(input int e);
    return (e - SY >= 0 && e - SY < PL) ? pin_a[e - SY] : 1'b0;
  endfunction

  // result of a capture whose rise search starts at the edge after st
  task automatic outcome(input int st, output int d, output int nw, output bit nto);
    int r, h;
    r = -1;
    for (int e = st + 1; e <= st + TO; e++)
      if (r < 0 && s_at(e) && !s_at(e - 1)) r = e;
    if (r < 0) begin
      d = st + TO; nw = 0; nto = 1'b1;
    end else begin
      h = 0;
      while (h <= TO && s_at(r + h)) h++;
      if (h <= TO) begin
        d = r + h; nw = h; nto = 1'b0;
      end else begin
        d = r + TO; nw = TO; nto = 1'b1;
      end
    end
  endtask

  task automatic build_expect(input int len);
    int k, d, nw, w, st;
    bit v, t, nto;
    k = 0; w = 0; v = 1'b0; t = 1'b0;
    while (k < len) begin
      if (arm_a[k]) begin
        st = k + TD;
        outcome(st, d, nw, nto);
        for (int j = k; j < d && j < len; j++) begin
          e_v[j] = 1'b0; e_t[j] = 1'b0; e_b[j] = 1'b1; e_w[j] = w; e_g[j] = (j < st);
        end
        v = 1'b1; t = nto; w = nw;
        if (d < len) begin
          e_v[d] = v; e_t[d] = t; e_b[d] = 1'b0; e_w[d] = w; e_g[d] = 1'b0;
        end
        k = d + 1;
      end else begin
        if (ack_a[k]) v = 1'b0;
        e_v[k] = v; e_t[k] = t; e_b[k] = 1'b0; e_w[k] = w; e_g[k] = 1'b0;
        k++;
      end
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < PL; i++) pin_a[i] = 1'b0;
    for (int i = 0; i < MAXL; i++) begin
      arm_a[i] = 1'b0; ack_a[i] = 1'b0;
    end
  endtask

  task automatic set_pin(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) pin_a[i] = 1'b1;
  endtask

  task automatic rand_stim(input int len);
    int k, n, r;
    bit lvl;
    clear_stim();
    k = 0; lvl = 1'b0;
    while (k < PL) begin
      r = int'($urandom_range(0, 7));
      n = (r == 0) ? int'($urandom_range(99, 101)) : (r == 1) ? int'($urandom_range(102, 140)) : int'($urandom_range(1, 60));
      for (int i = k; i < k + n && i < PL; i++) pin_a[i] = lvl;
      k += n; lvl = ~lvl;
    end
    for (int i = 0; i < len; i++) begin
      arm_a[i] = ($urandom_range(0, 11) == 0);
      ack_a[i] = ($urandom_range(0, 5) == 0);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_width"}, width_out, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef PULSE_CAPTURE_TRIG_EN
    chk({tag, "_trig"}, trig_out, 0);
`endif
  endtask

  // the single compare process: drive cycle k, then check the state left by edge k
  task automatic drive(input int len, input string tag);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      pin_in = pin_a[k]; arm = arm_a[k]; rd_ack = ack_a[k];
      @(posedge clk);
      #1;
      chk($sformatf("%s_valid@%0d", tag, k), valid, e_v[k]);
      chk($sformatf("%s_timeout@%0d", tag, k), timeout, e_t[k]);
      chk($sformatf("%s_busy@%0d", tag, k), busy, e_b[k]);
      chk($sformatf("%s_width@%0d", tag, k), width_out, e_w[k]);
`ifdef PULSE_CAPTURE_TRIG_EN
      chk($sformatf("%s_trig@%0d", tag, k), trig_out, e_g[k]);
`endif
    end
    @(negedge clk);
    arm = 1'b0; rd_ack = 1'b0;
    clr = 1'b1;
    #1;
    rst_chk({tag, "_clr"});
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #2 clr = 1'b1;
    #1 rst_chk("por");
    @(negedge clk);
    clr = 1'b0;
    clear_stim();
    arm_a[0] = 1'b1;
    set_pin(10, 46);
    ack_a[60] = 1'b1;
    arm_a[70] = 1'b1;
    arm_a[180] = 1'b1;
    set_pin(190, 319);
    set_pin(340, 359);
    arm_a[345] = 1'b1;
    set_pin(365, 376);
    arm_a[390] = 1'b1;
    ack_a[390] = 1'b1;
    ack_a[500] = 1'b1;
    build_expect(520);
    chk("model_basic_w", e_w[49], 37);
    chk("model_basic_v", e_v[49], 1);
    chk("model_basic_v_early", e_v[48], 0);
    chk("model_ack_v", e_v[60], 0);
    chk("model_ack_w", e_w[60], 37);
    chk("model_rise_to_early", e_v[169 + TD], 0);
    chk("model_rise_to_v", e_v[170 + TD], 1);
    chk("model_rise_to_t", e_t[170 + TD], 1);
    chk("model_rise_to_w", e_w[170 + TD], 0);
    chk("model_high_to_w", e_w[292], 100);
    chk("model_high_to_t", e_t[292], 1);
    chk("model_prearmed_w", e_w[379], 12);
    chk("model_arm_ack_v", e_v[390], 0);
    chk("model_arm_ack_b", e_b[390], 1);
`ifdef PULSE_CAPTURE_TRIG_EN
    chk("model_trig_last", e_g[TC - 1], 1);
    chk("model_trig_off", e_g[TC], 0);
`endif
    drive(520, "dir");
    rand_stim(2500);
    build_expect(2500);
    drive(2500, "rndA");
    rand_stim(2500);
    build_expect(2500);
    drive(2500, "rndB");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
